// File: rtl/mips_defs_pkg.sv
// Shared MIPS memory-stage definitions: load-kind encodings, load-unit FSM
// states and small decode helpers used by the load unit and its extender.
package mips_defs;

    localparam int unsigned XLEN = 32;
    localparam int unsigned LTW  = 3;

    // Load kinds as presented by the M stage; 3'b110/3'b111 are illegal.
    typedef enum logic [LTW-1:0] {
        LT_NONE = 3'd0,
        LT_LW   = 3'd1,
        LT_LH   = 3'd2,
        LT_LHU  = 3'd3,
        LT_LB   = 3'd4,
        LT_LBU  = 3'd5
    } l_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True for the five real load kinds; none and illegal codes are not loads.
    function automatic logic is_load(input logic [LTW-1:0] lt);
        logic r;
        case (lt)
            LT_LW, LT_LH, LT_LHU, LT_LB, LT_LBU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // Natural alignment: words on 4-byte, halves on 2-byte, bytes always.
    function automatic logic is_aligned(input logic [LTW-1:0] lt, input logic [1:0] a);
        logic r;
        case (lt)
            LT_LW:         r = (a == 2'b00);
            LT_LH, LT_LHU: r = (a[0] == 1'b0);
            default:       r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/m_load_ext.sv
// Combinational load lane select and sign/zero extension.
// Ports:
//   i_w      raw 32-bit word from data memory
//   i_a      byte offset of the load within the word
//   i_l_type load kind (mips_defs::l_type_e encoding)
//   o_value  extended 32-bit load result (0 for none/illegal kinds)
module m_load_ext
    import mips_defs::*;
(
    input  logic [XLEN-1:0] i_w,
    input  logic [1:0]      i_a,
    input  logic [LTW-1:0]  i_l_type,
    output logic [XLEN-1:0] o_value
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Lane select: halfword by a[1], byte by a[1:0].
    always_comb begin
        w_half = i_a[1] ? i_w[31:16] : i_w[15:0];
        case (i_a)
            2'd0:    w_byte = i_w[7:0];
            2'd1:    w_byte = i_w[15:8];
            2'd2:    w_byte = i_w[23:16];
            default: w_byte = i_w[31:24];
        endcase
    end

    // Extension by load kind.
    always_comb begin
        o_value = '0;
        case (i_l_type)
            LT_LW:   o_value = i_w;
            LT_LH:   o_value = {{16{w_half[15]}}, w_half};
            LT_LHU:  o_value = {16'h0000, w_half};
            LT_LB:   o_value = {{24{w_byte[7]}}, w_byte};
            LT_LBU:  o_value = {24'h000000, w_byte};
            default: o_value = '0;
        endcase
    end

endmodule

// File: rtl/m_load_unit.sv
// Memory-stage load unit: alignment check, word-aligned read to a
// variable-latency data memory, lane extraction and W-stage result return.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_addr/l_type  load request from the M stage
//   mem_rd_en/mem_addr         registered read request to data memory
//   mem_ready/mem_rdata        memory acknowledge and read word
//   stall                      combinational pipeline freeze (F/D/E/M)
//   rd_valid/rd_data           one-cycle result pulse and extended data
//   adel                       one-cycle misaligned-load exception pulse
//   bus_err                    one-cycle memory-timeout pulse
module m_load_unit
    import mips_defs::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [XLEN-1:0] req_addr,
    input  logic [LTW-1:0]  l_type,
    output logic            mem_rd_en,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall,
    output logic            rd_valid,
    output logic [XLEN-1:0] rd_data,
    output logic            adel,
    output logic            bus_err
);

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_a;
    logic [LTW-1:0]  r_lt;
    logic            r_mem_rd_en;
    logic [XLEN-1:0] r_mem_addr;
    logic            r_rd_valid;
    logic [XLEN-1:0] r_rd_data;
    logic            r_adel;
    logic            r_bus_err;

    state_e          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [1:0]      w_a_nxt;
    logic [LTW-1:0]  w_lt_nxt;
    logic            w_mem_rd_en_nxt;
    logic [XLEN-1:0] w_mem_addr_nxt;
    logic            w_rd_valid_nxt;
    logic [XLEN-1:0] w_rd_data_nxt;
    logic            w_adel_nxt;
    logic            w_bus_err_nxt;
    logic            w_stall;
    logic [XLEN-1:0] w_ext;

    m_load_ext u_ext (
        .i_w      (mem_rdata),
        .i_a      (r_a),
        .i_l_type (r_lt),
        .o_value  (w_ext)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_lt        <= LT_NONE;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_adel      <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_a         <= w_a_nxt;
            r_lt        <= w_lt_nxt;
            r_mem_rd_en <= w_mem_rd_en_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            r_rd_data   <= w_rd_data_nxt;
            r_adel      <= w_adel_nxt;
            r_bus_err   <= w_bus_err_nxt;
        end
    end

    // Next-state, next-output and stall decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_a_nxt         = r_a;
        w_lt_nxt        = r_lt;
        w_mem_rd_en_nxt = r_mem_rd_en;
        w_mem_addr_nxt  = r_mem_addr;
        w_rd_valid_nxt  = 1'b0;
        w_rd_data_nxt   = r_rd_data;
        w_adel_nxt      = 1'b0;
        w_bus_err_nxt   = 1'b0;
        w_stall         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req_valid && is_load(l_type)) begin
                    if (is_aligned(l_type, req_addr[1:0])) begin
                        w_state_nxt     = ST_WAIT;
                        w_cnt_nxt       = '0;
                        w_a_nxt         = req_addr[1:0];
                        w_lt_nxt        = l_type;
                        w_mem_rd_en_nxt = 1'b1;
                        w_mem_addr_nxt  = {req_addr[XLEN-1:2], 2'b00};
                        w_stall         = 1'b1;
                    end else begin
                        // Misaligned: raise the exception, never touch memory.
                        w_adel_nxt = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                w_stall = 1'b1;
                // An acknowledge in the last allowed cycle still wins.
                if (mem_ready) begin
                    w_rd_data_nxt   = w_ext;
                    w_rd_valid_nxt  = 1'b1;
                    w_mem_rd_en_nxt = 1'b0;
                    w_state_nxt     = ST_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_rd_data_nxt   = '0;
                    w_bus_err_nxt   = 1'b1;
                    w_mem_rd_en_nxt = 1'b0;
                    w_state_nxt     = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            // The instruction still sitting in M is the one just completed.
            ST_DONE: w_state_nxt = ST_IDLE;

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign stall     = w_stall;
    assign mem_rd_en = r_mem_rd_en;
    assign mem_addr  = r_mem_addr;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign adel      = r_adel;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_m_load_unit.sv
module tb_m_load_unit;

    localparam int TIMEOUT = 16;
    localparam int CW      = 5;

    localparam int K_NONE = 0;
    localparam int K_OK   = 1;
    localparam int K_ADEL = 2;
    localparam int K_TOUT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [2:0]  l_type;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        adel;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd = 32'h0;

    m_load_unit #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .l_type    (l_type),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .adel      (adel),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  lt;
        logic [31:0] addr;
        int          dly;
        logic [31:0] rdata;
        bit          hold;
        int          kind;
        logic [31:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: classify a request from the load rules.
    function automatic int classify(input logic [2:0] lt, input logic [31:0] addr);
        int k;
        if (lt < 3'd1 || lt > 3'd5) k = K_NONE;
        else if (lt == 3'd1 && (addr % 4) != 0) k = K_ADEL;
        else if ((lt == 3'd2 || lt == 3'd3) && (addr % 2) != 0) k = K_ADEL;
        else k = K_OK;
        return k;
    endfunction

    // Reference: extract and extend using shifts and arithmetic.
    function automatic logic [31:0] ref_ext(input logic [2:0] lt, input logic [31:0] addr,
                                            input logic [31:0] w);
        logic [31:0] v;
        int a;
        a = int'(addr % 4);
        v = 32'h0;
        case (lt)
            3'd1: v = w;
            3'd2, 3'd3: begin
                v = (w >> (16 * (a / 2))) & 32'h0000_FFFF;
                if (lt == 3'd2 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            3'd4, 3'd5: begin
                v = (w >> (8 * a)) & 32'h0000_00FF;
                if (lt == 3'd4 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // Drives one load request through its whole lifetime and checks every cycle.
    task automatic run_txn(input string tag, input logic [2:0] lt, input logic [31:0] addr,
                           input int dly, input logic [31:0] rdata, input bit hold,
                           input int kind, input logic [31:0] exp_data);
        int waits;
        // Accept cycle
        req_valid = 1'b1;
        req_addr  = addr;
        l_type    = lt;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        chk({tag, ".stall_acc"}, 32'(stall), 32'(kind == K_OK || kind == K_TOUT));
        next_cycle();

        if (kind == K_NONE || kind == K_ADEL) begin
            req_valid = 1'b0;
            mem_ready = 1'b0;
            #1;
            chk({tag, ".adel"}, 32'(adel), 32'(kind == K_ADEL));
            chk({tag, ".rd_en"}, 32'(mem_rd_en), 32'h0);
            chk({tag, ".stall"}, 32'(stall), 32'h0);
            chk({tag, ".rd_valid"}, 32'(rd_valid), 32'h0);
            chk({tag, ".rd_data_keep"}, rd_data, last_rd);
            next_cycle();
            #1;
            chk({tag, ".adel_end"}, 32'(adel), 32'h0);
            chk({tag, ".rd_en_end"}, 32'(mem_rd_en), 32'h0);
            return;
        end

        waits = (kind == K_OK) ? dly + 1 : TIMEOUT;
        for (int i = 0; i < waits; i++) begin
            if (hold) begin
                req_valid = 1'b1;
            end else begin
                req_valid = 1'($urandom_range(0, 1));
                req_addr  = $urandom;
                l_type    = 3'($urandom_range(0, 7));
            end
            mem_ready = (kind == K_OK && i == dly);
            mem_rdata = mem_ready ? rdata : $urandom;
            #1;
            chk({tag, ".stall_wait"}, 32'(stall), 32'h1);
            chk({tag, ".rd_en_wait"}, 32'(mem_rd_en), 32'h1);
            chk({tag, ".addr_wait"}, mem_addr, addr & 32'hFFFF_FFFC);
            chk({tag, ".rd_valid_wait"}, 32'(rd_valid), 32'h0);
            chk({tag, ".bus_err_wait"}, 32'(bus_err), 32'h0);
            next_cycle();
        end

        // Completion cycle; a held request is the same instruction.
        req_valid = hold;
        req_addr  = addr;
        l_type    = lt;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        chk({tag, ".stall_done"}, 32'(stall), 32'h0);
        chk({tag, ".rd_valid_done"}, 32'(rd_valid), 32'(kind == K_OK));
        chk({tag, ".bus_err_done"}, 32'(bus_err), 32'(kind == K_TOUT));
        chk({tag, ".rd_en_done"}, 32'(mem_rd_en), 32'h0);
        chk({tag, ".rd_data"}, rd_data, exp_data);
        last_rd = exp_data;
        next_cycle();

        req_valid = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        chk({tag, ".rd_valid_after"}, 32'(rd_valid), 32'h0);
        chk({tag, ".bus_err_after"}, 32'(bus_err), 32'h0);
        chk({tag, ".no_reaccess"}, 32'(mem_rd_en), 32'h0);
        chk({tag, ".stall_after"}, 32'(stall), 32'h0);
        mem_ready = 1'b0;
        next_cycle();
    endtask

    vec_t vecs[$];

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        l_type    = 3'd0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;

        vecs.push_back('{"lw_08",     3'd1, 32'h0000_0008, 1,  32'hDEAD_BEEF, 1'b0, K_OK,   32'hDEAD_BEEF});
        vecs.push_back('{"lb_13",     3'd4, 32'h0000_0013, 0,  32'h80FF_1234, 1'b0, K_OK,   32'hFFFF_FF80});
        vecs.push_back('{"lbu_13",    3'd5, 32'h0000_0013, 2,  32'h80FF_1234, 1'b0, K_OK,   32'h0000_0080});
        vecs.push_back('{"lh_22",     3'd2, 32'h0000_0022, 0,  32'h8001_7FFF, 1'b0, K_OK,   32'hFFFF_8001});
        vecs.push_back('{"lhu_22",    3'd3, 32'h0000_0022, 3,  32'h8001_7FFF, 1'b1, K_OK,   32'h0000_8001});
        vecs.push_back('{"lh_20",     3'd2, 32'h0000_0020, 1,  32'h8001_7FFF, 1'b0, K_OK,   32'h0000_7FFF});
        vecs.push_back('{"lw_06",     3'd1, 32'h0000_0006, 0,  32'h0,         1'b0, K_ADEL, 32'h0});
        vecs.push_back('{"lh_05",     3'd2, 32'h0000_0005, 0,  32'h0,         1'b0, K_ADEL, 32'h0});
        vecs.push_back('{"timeout",   3'd1, 32'h0000_0100, 0,  32'h0,         1'b1, K_TOUT, 32'h0});
        vecs.push_back('{"lb_01",     3'd4, 32'h0000_0001, 0,  32'h0000_7F00, 1'b0, K_OK,   32'h0000_007F});
        vecs.push_back('{"lhu_last",  3'd3, 32'h0000_0002, 15, 32'hFFFF_0000, 1'b0, K_OK,   32'h0000_FFFF});
        vecs.push_back('{"illegal6",  3'd6, 32'h0000_0000, 0,  32'h0,         1'b0, K_NONE, 32'h0});
        vecs.push_back('{"none",      3'd0, 32'h0000_0004, 0,  32'h0,         1'b0, K_NONE, 32'h0});

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset.rd_en", 32'(mem_rd_en), 32'h0);
        chk("reset.addr", mem_addr, 32'h0);
        chk("reset.rd_valid", 32'(rd_valid), 32'h0);
        chk("reset.rd_data", rd_data, 32'h0);
        chk("reset.adel", 32'(adel), 32'h0);
        chk("reset.bus_err", 32'(bus_err), 32'h0);
        chk("reset.stall", 32'(stall), 32'h0);
        next_cycle();

        foreach (vecs[i])
            run_txn(vecs[i].name, vecs[i].lt, vecs[i].addr, vecs[i].dly, vecs[i].rdata,
                    vecs[i].hold, vecs[i].kind, vecs[i].exp_data);

        // Reset in the second WAIT cycle, then a late acknowledge.
        req_valid = 1'b1;
        req_addr  = 32'h0000_0040;
        l_type    = 3'd1;
        mem_ready = 1'b0;
        #1;
        chk("rst_wait.stall_acc", 32'(stall), 32'h1);
        next_cycle();
        req_valid = 1'b0;
        #1;
        chk("rst_wait.rd_en", 32'(mem_rd_en), 32'h1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        chk("rst_wait.rd_en_off", 32'(mem_rd_en), 32'h0);
        chk("rst_wait.addr", mem_addr, 32'h0);
        chk("rst_wait.rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_wait.rd_data", rd_data, 32'h0);
        chk("rst_wait.stall", 32'(stall), 32'h0);
        chk("rst_wait.bus_err", 32'(bus_err), 32'h0);
        next_cycle();
        mem_ready = 1'b0;
        #1;
        chk("rst_wait.late_ready", 32'(rd_valid), 32'h0);
        chk("rst_wait.late_rd_en", 32'(mem_rd_en), 32'h0);
        last_rd = 32'h0;
        next_cycle();

        // Randomized loads checked against the reference rules.
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  lt;
            logic [31:0] addr;
            logic [31:0] w;
            int          dly;
            int          k;
            lt   = 3'($urandom_range(0, 7));
            addr = $urandom;
            w    = $urandom;
            dly  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 20))
                                               : int'($urandom_range(0, 4));
            k    = classify(lt, addr);
            if (k == K_OK && dly >= TIMEOUT) k = K_TOUT;
            run_txn($sformatf("rnd%0d", n), lt, addr, dly, w, 1'($urandom_range(0, 1)), k,
                    (k == K_OK) ? ref_ext(lt, addr, w) : (k == K_TOUT ? 32'h0 : last_rd));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_load_unit.md
Name: m_load_unit

Overview:
- Memory-stage load-side companion to the store byte-enable unit; it handles the read direction of the same data-memory interface.
- Accepts a load from the M stage, checks alignment, and issues a word-aligned read to a variable-latency data memory.
- Waits for the memory acknowledge, then selects the addressed byte/halfword lane and sign- or zero-extends it.
- Stalls the pipeline while the access is outstanding and returns the extended value for the W-stage writeback.

Parameters:
- TIMEOUT, 16: max cycles in WAIT without mem_ready before bus error; must be ≥2.
- CW, 5: width of the wait counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  M stage holds a load instruction
- req_addr  in  32  byte address of the load
- l_type  in  3  load kind: 000 none, 001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu; 11x illegal, treated as none
- mem_rd_en  out  1  read request to data memory, registered
- mem_addr  out  32  {addr[31:2],2'b00}, registered, stable while mem_rd_en=1
- mem_ready  in  1  memory acknowledge; mem_rdata valid in the same cycle
- mem_rdata  in  32  raw word read from memory
- stall  out  1  combinational: freeze F/D/E/M stage registers
- rd_valid  out  1  one-cycle pulse: rd_data valid for writeback
- rd_data  out  32  extended load result, registered
- adel  out  1  one-cycle pulse: misaligned load exception
- bus_err  out  1  one-cycle pulse: memory timeout

Behaviour:
- Interface decision (already decided): one clock; reset is synchronous and active-high, ports named clk and reset.
- Reset: state=IDLE, counter=0. mem_rd_en, mem_addr, rd_valid, rd_data, adel and bus_err all 0.
  - Reset mid-WAIT abandons the access and deasserts mem_rd_en on the next edge.
  - Any late mem_ready after reset is ignored.
- States:
  - IDLE: accepts a new load.
  - WAIT: read outstanding.
  - DONE: result presented for one cycle.
- Accept: in IDLE, when req_valid=1 and l_type ∈ {lw, lh, lhu, lb, lbu}.
- Alignment check, done on accept:
  - lw needs addr[1:0]=00.
  - lh/lhu need addr[0]=0.
  - lb/lbu are always aligned.
- Misaligned load:
  - No memory access; stay in IDLE.
  - adel=1 in the next cycle for exactly one cycle; stall=0 throughout.
  - rd_valid stays 0 and rd_data is unchanged.
- Aligned load:
  - Latch addr[1:0] and l_type; go to WAIT.
  - mem_rd_en=1 and mem_addr driven from the next cycle on.
  - stall=1 combinationally in the accept cycle.
- WAIT:
  - stall=1; the counter increments every cycle.
  - req_valid and req_addr are ignored (the instruction is frozen in M).
  - If mem_ready=1: capture the extended data into rd_data, drop mem_rd_en, go to DONE.
  - Else if counter=TIMEOUT-1: rd_data=0, drop mem_rd_en, go to DONE with bus_err=1.
  - mem_ready takes priority over timeout in the same cycle.
- DONE:
  - stall=0.
  - rd_valid=1 (or bus_err=1 on timeout), for exactly one cycle.
  - Always returns to IDLE.
  - req_valid=1 in DONE is the same instruction and must not be re-accepted.
- Latency: mem_ready in cycle k → rd_valid in k+1. Minimum accept-to-rd_valid is 3 cycles (ready in the first WAIT cycle).
- Extraction, with w=mem_rdata and a=latched addr[1:0]:
  - lw: w.
  - lh/lhu: half = a[1] ? w[31:16] : w[15:0], then sign/zero extend to 32 bits.
  - lb/lbu: byte = w[8a+7:8a], then sign/zero extend.
- mem_ready in IDLE or DONE: ignored.
- Counter: cleared on entry to WAIT; never wraps (bounded by TIMEOUT).

Decomposition:
- Shared package (mips_defs):
  - l_type encodings: LT_NONE, LT_LW, LT_LH, LT_LHU, LT_LB, LT_LBU.
  - State encodings: ST_IDLE, ST_WAIT, ST_DONE.
- One sub-module, m_load_ext:
  - Purely combinational lane select and extension; inputs w, a, l_type; output 32-bit value.
  - Shared with a future W-stage extender and unit-tested standalone.

Test Plan:
- lw addr=0x0000_0008, mem_ready after 2 WAIT cycles, rdata=0xDEAD_BEEF → stall high 3 cycles, mem_addr=0x08, then rd_valid=1 with rd_data=0xDEAD_BEEF for 1 cycle.
- lb / lbu, addr=0x13, rdata=0x80FF_1234 → lb gives rd_data=0xFFFF_FF80 and lbu gives 0x0000_0080; mem_addr=0x10.
- lh / lhu, addr=0x22, rdata=0x8001_7FFF → lh gives 0xFFFF_8001 and lhu gives 0x0000_8001. With addr=0x20: lh gives 0x0000_7FFF.
- lw addr=0x06 and lh addr=0x05 → adel pulses 1 cycle, mem_rd_en never rises, stall=0, rd_valid=0.
- mem_ready held 0, TIMEOUT=16 → 16 WAIT cycles, then bus_err=1 and rd_data=0. req_valid held high through DONE causes no second access.
- reset asserted in the 2nd WAIT cycle, then mem_ready=1 → all outputs 0 next cycle, state IDLE, late ready ignored, no rd_valid.
